flappy_game_engine: RTL and testbench



---
 rtl/flappy_pkg.sv | 29 ++
 rtl/flappy_game_engine_if.sv | 23 ++
 rtl/lfsr8.sv | 34 +++
 rtl/flappy_game_engine.sv | 192 +++++++++++++++++++
 tb/tb_flappy_game_engine.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared game-state type, screen/world constants and the LFSR step function for Flappy Block.
package flappy_pkg;

    typedef enum logic [1:0] {
        RUNNING   = 2'd0,
        PAUSED    = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned BIRD_X    = 30;
    localparam int unsigned BIRD_SIZE = 20;
    localparam int unsigned PIPE_W    = 30;
    localparam int unsigned GAP_H     = 70;
    localparam int unsigned GROUND_Y  = 220;

    localparam int unsigned BIRD_Y0    = 110;
    localparam int unsigned GAP_Y0     = 60;
    localparam int unsigned GAP_Y_STEP = 40;
    localparam int unsigned GAP_Y_MIN  = 20;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/flappy_game_engine_if.sv
// World interface between the frame/button source and the game engine.
interface flappy_game_engine_if #(
    parameter int unsigned NUM_PIPES = 3
);
    import flappy_pkg::*;

    logic        frame_tick;
    logic [1:0]  buttons;
    logic [9:0]  bird;
    logic [19:0] pipes [NUM_PIPES];
    game_state_t game_state;
    logic [7:0]  score;

    modport master (
        output frame_tick, buttons,
        input  bird, pipes, game_state, score
    );

    modport slave (
        input  frame_tick, buttons,
        output bird, pipes, game_state, score
    );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit LFSR; steps once per clock plus one extra step per requested draw.
module lfsr8
    import flappy_pkg::*;
#(
    parameter int unsigned MAX_DRAW = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(MAX_DRAW + 1)-1:0]   draw,
    output logic [7:0]                        value
);
    logic [7:0] r_lfsr;
    logic [7:0] w_next;

    always_comb begin
        w_next = lfsr_step(r_lfsr);
        for (int unsigned k = 0; k < MAX_DRAW; k++) begin
            if (k < 32'(draw)) begin
                w_next = lfsr_step(w_next);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_next;
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/flappy_game_engine.sv
// Flappy Block world engine: bird physics, pipe scroll/respawn, hit detection, score and game FSM.
// Define INVINCIBLE_EN to disable pipe collisions so that only the ground ends a game.
module flappy_game_engine
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES    = 3,
    parameter int unsigned PIPE_SPACING = 110,
    parameter int unsigned PIPE_SPEED   = 2,
    parameter int unsigned FLAP_VEL     = 6,
    parameter int unsigned MAX_FALL     = 8
) (
    input  logic                clk,
    input  logic                rst,
    flappy_game_engine_if.slave bus
);
    localparam int unsigned        DRAW_W   = $clog2(NUM_PIPES + 1);
    localparam logic signed [7:0]  FLAP_V   = 8'(FLAP_VEL);
    localparam logic signed [7:0]  FALL_V   = 8'(MAX_FALL);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);

    logic [1:0]         r_btn;
    logic [1:0]         r_btn_prev;
    game_state_t        r_state;
    game_state_t        w_state_nxt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic [9:0]         r_bird;
    logic [9:0]         w_bird_nxt;
    logic signed [7:0]  r_vel;
    logic signed [7:0]  w_vel_nxt;
    logic signed [7:0]  w_vel_calc;
    logic signed [10:0] w_y_new;
    logic [9:0]         r_px      [NUM_PIPES];
    logic [9:0]         r_gap     [NUM_PIPES];
    logic [9:0]         w_px_nxt  [NUM_PIPES];
    logic [9:0]         w_gap_nxt [NUM_PIPES];
    logic [7:0]         r_score;
    logic [7:0]         w_score_nxt;
    logic [7:0]         w_lfsr;
    logic [7:0]         w_rand;
    logic [DRAW_W-1:0]  w_draw;
    logic [DRAW_W-1:0]  w_draw_eff;
    logic               w_pause_edge;
    logic               w_flap_edge;
    logic               w_pipe_hit;
    logic               w_hit;
    logic               w_update;
    logic               w_reload;

    lfsr8 #(
        .MAX_DRAW(NUM_PIPES)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .draw (w_draw_eff),
        .value(w_lfsr)
    );

    assign w_pause_edge = r_btn[1] & ~r_btn_prev[1];
    assign w_flap_edge  = r_btn[0] & ~r_btn_prev[0];
    assign w_draw_eff   = w_update ? w_draw : '0;

    always_comb begin
`ifdef INVINCIBLE_EN
        w_pipe_hit = 1'b0;
`else
        w_pipe_hit = 1'b0;
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            if ((r_px[i] < 10'(BIRD_X + BIRD_SIZE))
                && ((11'(r_px[i]) + 11'(PIPE_W)) > 11'(BIRD_X))
                && ((r_bird < r_gap[i])
                    || ((11'(r_bird) + 11'(BIRD_SIZE)) > (11'(r_gap[i]) + 11'(GAP_H))))) begin
                w_pipe_hit = 1'b1;
            end
        end
`endif
        w_hit = (r_bird >= 10'(GROUND_Y)) || w_pipe_hit;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_update    = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            RUNNING: begin
                if (w_hit) begin
                    w_state_nxt = GAME_OVER;
                end else if (w_pause_edge) begin
                    w_state_nxt = PAUSED;
                end else if (bus.frame_tick) begin
                    w_update = 1'b1;
                end
            end
            PAUSED: begin
                if (w_pause_edge) begin
                    w_state_nxt = RUNNING;
                end
            end
            GAME_OVER: begin
                if (w_pause_edge) begin
                    w_reload    = 1'b1;
                    w_state_nxt = PAUSED;
                end
            end
            default: w_state_nxt = PAUSED;
        endcase
        // Flaps only accumulate while running and are consumed by the next frame update.
        w_pend_nxt = (r_state == RUNNING) && !w_update && (r_pend || w_flap_edge);
    end

    always_comb begin
        if (r_pend || w_flap_edge) begin
            w_vel_calc = -FLAP_V;
        end else if (r_vel < FALL_V) begin
            w_vel_calc = r_vel + 8'sd1;
        end else begin
            w_vel_calc = FALL_V;
        end
        w_y_new   = $signed({1'b0, r_bird}) + $signed({{3{w_vel_calc[7]}}, w_vel_calc});
        w_vel_nxt = w_vel_calc;
        if (w_y_new < 11'sd0) begin
            w_bird_nxt = '0;
            w_vel_nxt  = '0;
        end else if (w_y_new > GROUND_S) begin
            w_bird_nxt = 10'(GROUND_Y);
        end else begin
            w_bird_nxt = w_y_new[9:0];
        end

        // Each respawn in one frame consumes the next LFSR state in pipe order.
        w_rand      = w_lfsr;
        w_draw      = '0;
        w_score_nxt = r_score;
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            if (r_px[i] < 10'(PIPE_SPEED)) begin
                w_px_nxt[i]  = 10'(NUM_PIPES * PIPE_SPACING);
                w_gap_nxt[i] = 10'(GAP_Y_MIN) + {3'b000, w_rand[6:0]};
                w_rand       = lfsr_step(w_rand);
                w_draw       = w_draw + DRAW_W'(1);
                if (w_score_nxt != 8'hFF) begin
                    w_score_nxt = w_score_nxt + 8'd1;
                end
            end else begin
                w_px_nxt[i]  = r_px[i] - 10'(PIPE_SPEED);
                w_gap_nxt[i] = r_gap[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn      <= '0;
            r_btn_prev <= '0;
            r_state    <= PAUSED;
            r_pend     <= 1'b0;
        end else begin
            r_btn      <= bus.buttons;
            r_btn_prev <= r_btn;
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_reload) begin
            r_bird  <= 10'(BIRD_Y0);
            r_vel   <= '0;
            r_score <= '0;
            for (int i = 0; i < int'(NUM_PIPES); i++) begin
                r_px[i]  <= 10'(SCREEN_W + i * PIPE_SPACING);
                r_gap[i] <= 10'(GAP_Y0 + i * GAP_Y_STEP);
            end
        end else if (w_update) begin
            r_bird  <= w_bird_nxt;
            r_vel   <= w_vel_nxt;
            r_score <= w_score_nxt;
            for (int i = 0; i < int'(NUM_PIPES); i++) begin
                r_px[i]  <= w_px_nxt[i];
                r_gap[i] <= w_gap_nxt[i];
            end
        end
    end

    assign bus.bird       = r_bird;
    assign bus.game_state = r_state;
    assign bus.score      = r_score;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        assign bus.pipes[g] = {r_px[g], r_gap[g]};
    end

endmodule

// File: tb/tb_flappy_game_engine.sv
// Bench for flappy_game_engine: directed scenarios with literal expectations plus randomized
// play compared every cycle against a behavioural world model.
module tb_flappy_game_engine;
    import flappy_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flappy_game_engine_if #(.NUM_PIPES(NP)) bus ();

    flappy_game_engine #(
        .NUM_PIPES   (NP),
        .PIPE_SPACING(110),
        .PIPE_SPEED  (2),
        .FLAP_VEL    (6),
        .MAX_FALL    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_print  = 0;

    // Behavioural world: state 0 running, 1 paused, 2 game over.
    int       m_state, m_bird, m_vel, m_score, m_lfsr;
    int       m_px  [NP];
    int       m_gap [NP];
    bit       m_pend, m_valid;
    bit [1:0] m_h1, m_h2;
    bit       s_rst, s_tick;
    bit [1:0] s_btn;

    function automatic int lfsr_adv(input int v);
        return ((v << 1) | ($countones(v & 8'hB8) & 1)) & 8'hFF;
    endfunction

    task automatic world_reset(input bit full);
        m_state = 1;
        m_bird  = 110;
        m_vel   = 0;
        m_score = 0;
        m_pend  = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_px[i]  = 320 + i * 110;
            m_gap[i] = 60 + i * 40;
        end
        if (full) begin
            m_lfsr = 8'hA5;
            m_h1   = 2'b00;
            m_h2   = 2'b00;
        end
    endtask

    function automatic bit model_hit();
        bit h;
        h = (m_bird >= 220);
`ifndef INVINCIBLE_EN
        for (int i = 0; i < NP; i++) begin
            if (m_px[i] < 50 && m_px[i] + 30 > 30
                && (m_bird < m_gap[i] || m_bird + 20 > m_gap[i] + 70)) h = 1'b1;
        end
`endif
        return h;
    endfunction

    task automatic model_edge(input bit r, input bit t, input bit [1:0] b);
        bit pe, fe, hit, run;
        int lf, vel, y, st0;
        if (r) begin
            world_reset(1'b1);
            m_valid = 1'b1;
            return;
        end
        pe  = m_h1[1] & ~m_h2[1];
        fe  = m_h1[0] & ~m_h2[0];
        hit = model_hit();
        st0 = m_state;
        run = (st0 == 0);
        lf  = m_lfsr;
        if (run && !hit && !pe && t) begin
            vel = (m_pend || fe) ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
            y   = m_bird + vel;
            if (y < 0) begin
                y   = 0;
                vel = 0;
            end else if (y > 220) begin
                y = 220;
            end
            m_bird = y;
            m_vel  = vel;
            for (int i = 0; i < NP; i++) begin
                if (m_px[i] < 2) begin
                    m_px[i]  = 330;
                    m_gap[i] = 20 + (lf % 128);
                    lf       = lfsr_adv(lf);
                    if (m_score < 255) m_score++;
                end else begin
                    m_px[i] -= 2;
                end
            end
            m_pend = 1'b0;
        end else if (run) begin
            m_pend = m_pend | fe;
        end else begin
            m_pend = 1'b0;
        end
        if (run && hit) m_state = 2;
        else if (pe && st0 == 0) m_state = 1;
        else if (pe && st0 == 1) m_state = 0;
        else if (pe && st0 == 2) world_reset(1'b0);
        m_lfsr = lfsr_adv(lf);
        m_h2   = m_h1;
        m_h1   = b;
    endtask

    task automatic compare_world();
        bit ok;
        ok = (bus.bird === 10'(m_bird)) && (bus.game_state === 2'(m_state))
             && (bus.score === 8'(m_score));
        for (int i = 0; i < NP; i++) begin
            if (bus.pipes[i] !== {10'(m_px[i]), 10'(m_gap[i])}) ok = 1'b0;
        end
        n_checks++;
        if (ok) begin
            n_pass++;
        end else if (n_print < 20) begin
            n_print++;
            $display("FAIL world t=%0t: got bird=%0d st=%0d sc=%0d p=%0d/%0d %0d/%0d %0d/%0d, expected bird=%0d st=%0d sc=%0d p=%0d/%0d %0d/%0d %0d/%0d",
                     $time, bus.bird, bus.game_state, bus.score,
                     bus.pipes[0][19:10], bus.pipes[0][9:0], bus.pipes[1][19:10],
                     bus.pipes[1][9:0], bus.pipes[2][19:10], bus.pipes[2][9:0],
                     m_bird, m_state, m_score, m_px[0], m_gap[0], m_px[1], m_gap[1],
                     m_px[2], m_gap[2]);
        end
    endtask

    always @(posedge clk) begin
        s_rst  = rst;
        s_tick = bus.frame_tick;
        s_btn  = bus.buttons;
        model_edge(s_rst, s_tick, s_btn);
        #2;
        if (m_valid) compare_world();
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int px(input int i);
        return int'(bus.pipes[i][19:10]);
    endfunction

    function automatic int gp(input int i);
        return int'(bus.pipes[i][9:0]);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(2);
    endtask

    task automatic press(input int b);
        bus.buttons[b] = 1'b1;
        step(3);
        bus.buttons[b] = 1'b0;
        step(3);
    endtask

    // Flap whenever the bird is low on screen, then tick; returns just after the tick edge.
    task automatic fly_tick();
        if (bus.bird > 10'd40) begin
            bus.buttons[0] = 1'b1;
            step(1);
            bus.buttons[0] = 1'b0;
            step(1);
        end else begin
            step(2);
        end
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        int  px_hold, since;
        bit  reached;
        bus.frame_tick = 1'b0;
        bus.buttons    = 2'b00;
        step(3);
        rst = 1'b0;
        step(1);

        repeat (5) do_tick();
        chk("rst_bird", int'(bus.bird), 110);
        chk("rst_x0", px(0), 320);
        chk("rst_x1", px(1), 430);
        chk("rst_x2", px(2), 540);
        chk("rst_gap0", gp(0), 60);
        chk("rst_gap1", gp(1), 100);
        chk("rst_gap2", gp(2), 140);
        chk("rst_state", int'(bus.game_state), 1);
        chk("rst_score", int'(bus.score), 0);

        press(1);
        chk("run_state", int'(bus.game_state), 0);
        do_tick();
        chk("grav_1", int'(bus.bird), 111);
        do_tick();
        chk("grav_2", int'(bus.bird), 113);
        do_tick();
        chk("grav_3", int'(bus.bird), 116);
        chk("grav_x0", px(0), 314);

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        press(1);
        press(0);
        do_tick();
        chk("flap_1", int'(bus.bird), 104);
        do_tick();
        chk("flap_2", int'(bus.bird), 99);

        reached = 1'b0;
        for (int k = 0; k < 60 && !reached; k++) begin
            bus.frame_tick = 1'b1;
            step(1);
            bus.frame_tick = 1'b0;
            if (bus.bird == 10'd220) begin
                reached = 1'b1;
                chk("ground_same_edge", int'(bus.game_state), 0);
                step(1);
                chk("ground_over", int'(bus.game_state), 2);
            end
            step(2);
        end
        chk("ground_reached", int'(reached), 1);
        px_hold = px(0);
        repeat (3) do_tick();
        chk("over_bird_hold", int'(bus.bird), 220);
        chk("over_x_hold", px(0), px_hold);
        chk("over_state_hold", int'(bus.game_state), 2);
        press(1);
        chk("reload_bird", int'(bus.bird), 110);
        chk("reload_x0", px(0), 320);
        chk("reload_gap1", gp(1), 100);
        chk("reload_score", int'(bus.score), 0);
        chk("reload_state", int'(bus.game_state), 1);

        press(1);
        chk("run_again", int'(bus.game_state), 0);
`ifdef INVINCIBLE_EN
        for (int t = 1; t <= 161; t++) fly_tick();
        chk("respawn_x0", px(0), 330);
        chk("respawn_score", int'(bus.score), 1);
        chk("respawn_gap_range", int'(gp(0) >= 20 && gp(0) <= 147), 1);
        chk("respawn_state", int'(bus.game_state), 0);
`else
        for (int t = 1; t <= 136; t++) fly_tick();
        chk("coll_x0", px(0), 48);
        chk("coll_same_edge", int'(bus.game_state), 0);
        step(1);
        chk("coll_over", int'(bus.game_state), 2);
        do_tick();
        do_tick();
        chk("coll_x0_frozen", px(0), 48);
        chk("coll_x1_frozen", px(1), 158);
`endif

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        since = 2;
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (since >= 2 && $urandom_range(0, 3) == 0) begin
                bus.frame_tick = 1'b1;
                since = 0;
            end else begin
                bus.frame_tick = 1'b0;
                since++;
            end
            if ($urandom_range(0, 3) == 0) bus.buttons[0] = ~bus.buttons[0];
            if ($urandom_range(0, 49) == 0) bus.buttons[1] = ~bus.buttons[1];
            step(1);
        end
        rst            = 1'b0;
        bus.frame_tick = 1'b0;
        bus.buttons    = 2'b00;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
